// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane decode helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_t;

    // Little-endian byte enables for a transfer of the given size at addr[1:0].
    function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word-organised SRAM with per-byte write enables and an asynchronous read port.
module ahb_slave_mem #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata_c
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with configurable wait states and two-cycle ERROR responses.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    slv_state_t       state;
    logic [IDX_W+1:0] addr_q;
    logic             write_q;
    logic [2:0]       size_q;
    logic             err_q;
    logic [3:0]       wait_cnt;
    logic             hreadyout_q;
    logic [1:0]       hresp_q;

    logic             accept_c;
    logic             addr_err_c;
    logic             mem_we_c;
    logic [31:0]      rdata_c;

    // Only states that drive HREADYOUT high can take a new address phase.
    assign accept_c = HSEL && HREADY && hreadyout_q &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    // Depth is a power of two, so out-of-range means any address bit above the index is set.
    always_comb begin
        addr_err_c = 1'b0;
        if (HSIZE > HSIZE_WORD)                             addr_err_c = 1'b1;
        if ((HSIZE == HSIZE_HALF) && HADDR[0])              addr_err_c = 1'b1;
        if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) addr_err_c = 1'b1;
        if (|HADDR[ADDR_WIDTH-1:IDX_W+2])                   addr_err_c = 1'b1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            err_q       <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (accept_c) begin
                addr_q  <= HADDR[IDX_W+1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE;
                err_q   <= addr_err_c;
            end
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state       <= ST_DATA;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    if (!accept_c) begin
                        state       <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end else if (addr_err_c) begin
                        state       <= ST_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end else if (WAIT_STATES > 0) begin
                        state       <= ST_WAIT;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_OKAY;
                        wait_cnt    <= WAIT_LOAD;
                    end else begin
                        state       <= ST_DATA;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // The write lands on the edge that closes the data phase, ahead of any pipelined read.
    assign mem_we_c = (state == ST_DATA) && write_q && !err_q;

    ahb_slave_mem #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (HCLK),
        .we      (mem_we_c),
        .be      (lane_enable(size_q, addr_q[1:0])),
        .waddr   (addr_q[IDX_W+1:2]),
        .wdata   (HWDATA),
        .raddr   (addr_q[IDX_W+1:2]),
        .rdata_c (rdata_c)
    );

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = (state == ST_DATA) ? rdata_c : '0;

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
Synthesizable AHB-Lite responder: a word-organised SRAM target with configurable wait states and ERROR responses. It is the slave-side counterpart of the verification AHB master and sits on the AHB side of the AHB-APB bridge subsystem as a memory target and bridge-testbench reference slave. It supports byte, halfword and word accesses, and returns a two-cycle ERROR for illegal transfers.

Parameters:
ADDR_WIDTH, 32, HADDR width
DATA_WIDTH, 32, HWDATA/HRDATA width (fixed 32 for this block)
MEM_DEPTH, 256, number of 32-bit words (power of 2)
WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase (0..15)

Ports:
HCLK  in  1  single clock, all logic on rising edge
HRESET  in  1  asynchronous, active-high reset
HSEL  in  1  slave select from decoder
HADDR  in  ADDR_WIDTH  address
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  in  1  1=write, 0=read
HSIZE  in  3  000 byte, 001 halfword, 010 word
HWDATA  in  DATA_WIDTH  write data (data phase)
HREADY  in  1  bus-level ready (previous transfer complete)
HREADYOUT  out  1  slave ready
HRESP  out  2  00 OKAY, 01 ERROR
HRDATA  out  DATA_WIDTH  read data

Behaviour:
- Reset (async, active-high): state IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, captured address/control cleared. Memory contents are not reset.
- Address phase accepted when HSEL && HREADY && HTRANS[1]=1. BUSY and IDLE are treated as no transfer: OKAY, zero wait. SEQ is handled identically to NONSEQ.
- Accepted phase registers: addr_q, write_q, size_q, and err_q.
- err_q is set when any of the following holds:
  - HSIZE>2
  - halfword with HADDR[0]=1
  - word with HADDR[1:0]!=0
  - HADDR[ADDR_WIDTH-1:2] >= MEM_DEPTH
- Word index = HADDR[clog2(MEM_DEPTH)+1:2]. Little-endian lanes: byte lane = HADDR[1:0]; halfword lanes = {HADDR[1],0}+{0,1}.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on accept, go to ERR1 if err_q. Otherwise go to WAIT if WAIT_STATES>0, else DATA.
  - WAIT: HREADYOUT=0, HRESP=00. A down-counter loads WAIT_STATES-1 and decrements; at 0 go to DATA.
  - DATA: HREADYOUT=1, HRESP=00. Transfer completes this cycle. A new accepted phase in the same cycle is handled with the IDLE transitions (pipelining). Otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=01. Always go to ERR2. Address phases presented here are ignored, because HREADY is low.
  - ERR2: HREADYOUT=1, HRESP=01. A new accepted phase in this cycle is handled as in IDLE; otherwise go to IDLE.
- Zero-wait latency: address phase in cycle N, data phase completes in cycle N+1. With WAIT_STATES=k, the data phase completes in cycle N+1+k.
- Writes: only enabled byte lanes of HWDATA are written, at the HCLK edge that ends the DATA state. Errored writes never modify memory.
- Reads: HRDATA = mem[addr_q] in the DATA state (combinational from the registered index). HRDATA is 0 in all other states, including ERR1/ERR2. Full word is returned regardless of HSIZE.
- Write followed by read to the same address, back-to-back: the read returns the new data. The write commits at the edge entering the read's data phase.
- Reset asserted mid-transfer (WAIT or ERR1): immediate return to IDLE/OKAY/ready. A pending write is discarded.
- HSEL low in an address phase: not accepted, and the FSM still finishes any current data phase.

Decomposition:
- Shared package/include ahb_pkg:
  - HTRANS codes
  - HRESP codes (OKAY/ERROR)
  - HSIZE codes
  - slave FSM state encoding
  - lane-enable function (size, addr[1:0] -> 4-bit byte enable)
- Sub-module ahb_slave_mem: MEM_DEPTH x 32 array with 4-bit byte-write enable, synchronous write and asynchronous read port.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 -> HREADYOUT stays 1, HRESP=00, HRDATA=0xDEADBEEF in the cycle after the read address phase.
- Byte writes 0x11 to 0x20, 0x22 to 0x21, 0x33 to 0x22, 0x44 to 0x23 (HSIZE=0), then word read of 0x20 -> 0x44332211. Also halfword 0xAAAA written to 0x22 -> read 0xAAAA2211.
- WAIT_STATES=3: read 0x10 -> HREADYOUT low for exactly 3 cycles, then high with data; HRESP=00 throughout.
- Read 0x400 with MEM_DEPTH=256 -> cycle1 HREADYOUT=0/HRESP=01, cycle2 HREADYOUT=1/HRESP=01, HRDATA=0. A word write to 0x2 gives the same ERROR response, and memory at 0x0 is unchanged.
- Back-to-back pipelined NONSEQ: write 0x12345678 to 0x30 immediately followed by read 0x30 -> read returns 0x12345678 with no extra wait. BUSY/IDLE cycles inserted -> OKAY, HREADYOUT=1.
- Assert HRESET during the 2nd wait cycle of a write to 0x40 (WAIT_STATES=3) -> HREADYOUT=1 and HRESP=00 immediately. A subsequent read of 0x40 returns the previously written value (0x0 pre-loaded by an earlier write).
